// File: rtl/cu_pkg.sv
// cu_pkg -- shared types and constants for the multicycle control unit.
//   state_t : control FSM states
//   OPC_*   : RV32 major opcodes (IR[6:0]) decoded in EXEC
//   PCS_*   : PC mux select encoding driven on PC_SOURCE
package cu_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_TRAP  = 3'd4
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // SYSTEM with FUNCT3 == 000 is treated as mret; everything else is a CSR op.
  localparam logic [2:0] F3_PRIV    = 3'b000;

  localparam logic [2:0] PCS_MEPC   = 3'b000;
  localparam logic [2:0] PCS_MTVEC  = 3'b001;
  localparam logic [2:0] PCS_JAL    = 3'b010;
  localparam logic [2:0] PCS_BRANCH = 3'b011;
  localparam logic [2:0] PCS_JALR   = 3'b100;
  localparam logic [2:0] PCS_PC4    = 3'b101;

endpackage

// File: rtl/branch_eval.sv
// branch_eval -- combinational branch-taken decision from FUNCT3 and the
// rs1/rs2 comparator flags.
//   funct3 : branch kind (IR[14:12])
//   br_eq, br_lt, br_ltu : comparator results
//   taken  : 1 when the branch condition holds (010/011 never taken)
module branch_eval (
  input  logic [2:0] funct3,
  input  logic       br_eq,
  input  logic       br_lt,
  input  logic       br_ltu,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = br_eq;
      3'b001:  taken = ~br_eq;
      3'b100:  taken = br_lt;
      3'b101:  taken = ~br_lt;
      3'b110:  taken = br_ltu;
      3'b111:  taken = ~br_ltu;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cu_fsm.sv
// cu_fsm -- multicycle RV32 control unit: INIT/FETCH/EXEC/WB/TRAP.
//   CLK, RST          : clock, synchronous active-high reset (-> INIT)
//   OPCODE, FUNCT3    : instruction fields, valid in EXEC
//   BR_EQ/LT/LTU      : comparator flags, valid in EXEC
//   INTR, MIE         : interrupt request level and global enable
//   PC_RST, PC_WRITE, PC_SOURCE       : PC control
//   MEM_RDEN1, MEM_RDEN2, MEM_WE2     : instruction/data memory strobes
//   REG_WRITE, CSR_WE                 : register/CSR write enables
//   INT_TAKEN, MRET_EXEC              : trap entry / mret retire
module cu_fsm
  import cu_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] OPCODE,
  input  logic [2:0] FUNCT3,
  input  logic       BR_EQ,
  input  logic       BR_LT,
  input  logic       BR_LTU,
  input  logic       INTR,
  input  logic       MIE,
  output logic       PC_RST,
  output logic       PC_WRITE,
  output logic [2:0] PC_SOURCE,
  output logic       MEM_RDEN1,
  output logic       MEM_RDEN2,
  output logic       MEM_WE2,
  output logic       REG_WRITE,
  output logic       CSR_WE,
  output logic       INT_TAKEN,
  output logic       MRET_EXEC
);

  state_t state, state_nxt;
  logic   br_taken;
  logic   irq;

  assign irq = INTR & MIE;

  branch_eval u_branch_eval (
    .funct3 (FUNCT3),
    .br_eq  (BR_EQ),
    .br_lt  (BR_LT),
    .br_ltu (BR_LTU),
    .taken  (br_taken)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_INIT;
    else     state <= state_nxt;
  end

  // Interrupts are only looked at on an instruction's last cycle
  // (EXEC for non-loads, WB for loads), so a trap never splits a load.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:  state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (OPCODE == OPC_LOAD) state_nxt = ST_WB;
        else if (irq)           state_nxt = ST_TRAP;
        else                    state_nxt = ST_FETCH;
      end
      ST_WB:    state_nxt = irq ? ST_TRAP : ST_FETCH;
      ST_TRAP:  state_nxt = ST_FETCH;
      default:  state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    PC_RST    = 1'b0;
    PC_WRITE  = 1'b0;
    PC_SOURCE = PCS_PC4;
    MEM_RDEN1 = 1'b0;
    MEM_RDEN2 = 1'b0;
    MEM_WE2   = 1'b0;
    REG_WRITE = 1'b0;
    CSR_WE    = 1'b0;
    INT_TAKEN = 1'b0;
    MRET_EXEC = 1'b0;
    case (state)
      ST_INIT:  PC_RST    = 1'b1;
      ST_FETCH: MEM_RDEN1 = 1'b1;
      ST_EXEC: begin
        // Loads retire in WB; every other opcode moves the PC here.
        PC_WRITE = (OPCODE != OPC_LOAD);
        case (OPCODE)
          OPC_LOAD:   MEM_RDEN2 = 1'b1;
          OPC_STORE:  MEM_WE2   = 1'b1;
          OPC_BRANCH: PC_SOURCE = br_taken ? PCS_BRANCH : PCS_PC4;
          OPC_JAL: begin
            REG_WRITE = 1'b1;
            PC_SOURCE = PCS_JAL;
          end
          OPC_JALR: begin
            REG_WRITE = 1'b1;
            PC_SOURCE = PCS_JALR;
          end
          OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC: REG_WRITE = 1'b1;
          OPC_SYSTEM: begin
            if (FUNCT3 == F3_PRIV) begin
              PC_SOURCE = PCS_MEPC;
              MRET_EXEC = 1'b1;
            end else begin
              REG_WRITE = 1'b1;
              CSR_WE    = 1'b1;
            end
          end
          default: ;  // unknown opcode executes as a NOP
        endcase
      end
      ST_WB: begin
        REG_WRITE = 1'b1;
        PC_WRITE  = 1'b1;
      end
      ST_TRAP: begin
        PC_WRITE  = 1'b1;
        PC_SOURCE = PCS_MTVEC;
        INT_TAKEN = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cu_fsm.sv
// tb_cu_fsm -- scoreboard bench for cu_fsm. The driver works one instruction
// at a time: from the instruction's class it derives the per-cycle output
// vectors it must produce and queues them; a negedge monitor pops and compares.
module tb_cu_fsm;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [6:0] OPCODE = '0;
  logic [2:0] FUNCT3 = '0;
  logic       BR_EQ = 1'b0, BR_LT = 1'b0, BR_LTU = 1'b0;
  logic       INTR = 1'b0, MIE = 1'b0;
  logic       PC_RST, PC_WRITE, MEM_RDEN1, MEM_RDEN2, MEM_WE2;
  logic       REG_WRITE, CSR_WE, INT_TAKEN, MRET_EXEC;
  logic [2:0] PC_SOURCE;

  cu_fsm dut (
    .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .FUNCT3(FUNCT3),
    .BR_EQ(BR_EQ), .BR_LT(BR_LT), .BR_LTU(BR_LTU), .INTR(INTR), .MIE(MIE),
    .PC_RST(PC_RST), .PC_WRITE(PC_WRITE), .PC_SOURCE(PC_SOURCE),
    .MEM_RDEN1(MEM_RDEN1), .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2),
    .REG_WRITE(REG_WRITE), .CSR_WE(CSR_WE), .INT_TAKEN(INT_TAKEN),
    .MRET_EXEC(MRET_EXEC)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      tag;
    logic [11:0] exp;
  } sb_t;
  sb_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  // Output vector layout: {PC_RST, PC_WRITE, PC_SOURCE, MEM_RDEN1, MEM_RDEN2,
  // MEM_WE2, REG_WRITE, CSR_WE, INT_TAKEN, MRET_EXEC}
  function automatic logic [11:0] ov(input logic prst, input logic pcw, input logic [2:0] src,
                                     input logic rd1, input logic rd2, input logic we2,
                                     input logic rw, input logic csr, input logic itk,
                                     input logic mr);
    return {prst, pcw, src, rd1, rd2, we2, rw, csr, itk, mr};
  endfunction

  localparam logic [11:0] V_INIT  = 12'b1_0_101_0000000;
  localparam logic [11:0] V_FETCH = 12'b0_0_101_1000000;
  localparam logic [11:0] V_WB    = 12'b0_1_101_0001000;
  localparam logic [11:0] V_TRAP  = 12'b0_1_001_0000010;

  function automatic logic br_rule(input logic [2:0] f3, input logic eq, input logic lt,
                                   input logic ltu);
    logic flag;
    if (f3[2:1] == 2'b01) return 1'b0;
    flag = f3[2] ? (f3[1] ? ltu : lt) : eq;
    return flag ^ f3[0];
  endfunction

  function automatic logic [11:0] exec_vec(input logic [6:0] op, input logic [2:0] f3,
                                           input logic eq, input logic lt, input logic ltu);
    case (op)
      7'b0000011: return ov(0, 0, 3'd5, 0, 1, 0, 0, 0, 0, 0);
      7'b0100011: return ov(0, 1, 3'd5, 0, 0, 1, 0, 0, 0, 0);
      7'b1100011: return ov(0, 1, br_rule(f3, eq, lt, ltu) ? 3'd3 : 3'd5, 0, 0, 0, 0, 0, 0, 0);
      7'b1101111: return ov(0, 1, 3'd2, 0, 0, 0, 1, 0, 0, 0);
      7'b1100111: return ov(0, 1, 3'd4, 0, 0, 0, 1, 0, 0, 0);
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111:
                  return ov(0, 1, 3'd5, 0, 0, 0, 1, 0, 0, 0);
      7'b1110011: return (f3 == 3'd0) ? ov(0, 1, 3'd0, 0, 0, 0, 0, 0, 0, 1)
                                      : ov(0, 1, 3'd5, 0, 0, 0, 1, 1, 0, 0);
      default:    return ov(0, 1, 3'd5, 0, 0, 0, 0, 0, 0, 0);
    endcase
  endfunction

  // One clock of stimulus; exp is what the DUT must show during that cycle.
  task automatic cyc(input logic rst, input logic [6:0] op, input logic [2:0] f3,
                     input logic [2:0] flags, input logic intr, input logic mie,
                     input string tag, input logic [11:0] exp);
    sb_t e;
    @(posedge CLK);
    #1;
    RST = rst; OPCODE = op; FUNCT3 = f3;
    {BR_EQ, BR_LT, BR_LTU} = flags;
    INTR = intr; MIE = mie;
    e.tag = tag; e.exp = exp;
    sb.push_back(e);
  endtask

  // Cycle with don't-care instruction fields and a random interrupt level,
  // used where the DUT must ignore both (INIT, FETCH, TRAP).
  task automatic idle_cyc(input logic rst, input string tag, input logic [11:0] exp);
    cyc(rst, 7'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), tag, exp);
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [2:0] fl,
                           input logic intr, input logic mie, input logic rst_last,
                           input logic rst_trap);
    logic [11:0] ev;
    ev = exec_vec(op, f3, fl[2], fl[1], fl[0]);
    idle_cyc(1'b0, "fetch", V_FETCH);
    if (op == 7'b0000011) begin
      cyc(1'b0, op, f3, fl, 1'($urandom), 1'($urandom), "exec_load", ev);
      cyc(rst_last, op, f3, fl, intr, mie, "wb", V_WB);
    end else begin
      cyc(rst_last, op, f3, fl, intr, mie, "exec", ev);
    end
    if (rst_last) begin
      idle_cyc(1'b0, "init_after_rst", V_INIT);
    end else if (intr && mie) begin
      idle_cyc(rst_trap, "trap", V_TRAP);
      if (rst_trap) idle_cyc(1'b0, "init_after_trap_rst", V_INIT);
    end
  endtask

  always @(negedge CLK) begin
    sb_t e;
    logic [11:0] got;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      got = {PC_RST, PC_WRITE, PC_SOURCE, MEM_RDEN1, MEM_RDEN2, MEM_WE2,
             REG_WRITE, CSR_WE, INT_TAKEN, MRET_EXEC};
      vectors++;
      if (got !== e.exp) begin
        miscompares++;
        $display("FAIL %s at %0t: got=%b expected=%b", e.tag, $time, got, e.exp);
      end
    end
  end

  localparam logic [6:0] OPS [11] = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
                                      7'b1100111, 7'b0110011, 7'b0010011, 7'b0110111,
                                      7'b0010111, 7'b1110011, 7'b1111111};

  initial begin
    logic [6:0] op;
    // Two reset edges, then release: INIT is visible from the first edge.
    cyc(1'b1, '0, '0, '0, 1'b1, 1'b1, "rst_hold", V_INIT);
    cyc(1'b0, '0, '0, '0, 1'b1, 1'b1, "init", V_INIT);

    // Directed cases
    run_instr(7'b1100011, 3'b001, 3'b000, 0, 0, 0, 0);   // BNE taken
    run_instr(7'b1100011, 3'b001, 3'b100, 0, 0, 0, 0);   // BNE not taken
    run_instr(7'b1100011, 3'b011, 3'b111, 0, 0, 0, 0);   // never-taken funct3
    run_instr(7'b0000011, 3'b010, 3'b000, 0, 0, 0, 0);   // load, 3 cycles
    run_instr(7'b0010011, 3'b000, 3'b000, 1, 1, 0, 0);   // OP-IMM + irq -> TRAP
    run_instr(7'b0010011, 3'b000, 3'b000, 1, 0, 0, 0);   // MIE=0 -> no TRAP
    run_instr(7'b1110011, 3'b000, 3'b000, 0, 0, 0, 0);   // mret
    run_instr(7'b1110011, 3'b000, 3'b000, 1, 1, 0, 0);   // mret then TRAP
    run_instr(7'b1110011, 3'b010, 3'b000, 0, 0, 0, 0);   // CSR op
    run_instr(7'b0000011, 3'b010, 3'b000, 1, 1, 1, 0);   // reset mid-WB
    run_instr(7'b0000011, 3'b010, 3'b000, 1, 1, 0, 0);   // load then TRAP
    run_instr(7'b1111111, 3'b000, 3'b000, 0, 0, 0, 0);   // illegal -> NOP
    run_instr(7'b1101111, 3'b000, 3'b000, 0, 0, 0, 0);   // JAL
    run_instr(7'b1100111, 3'b000, 3'b000, 0, 0, 0, 0);   // JALR
    run_instr(7'b0100011, 3'b010, 3'b000, 1, 1, 0, 1);   // store, reset in TRAP

    // Randomized instruction stream
    for (int i = 0; i < 400; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 7'($urandom) : OPS[$urandom_range(0, 10)];
      run_instr(op, 3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0));
    end

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got=%0d pending expected=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
